// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-FU result holding slots with round-robin CDB broadcast and branch squash
module cdb_arbiter #(
   parameter int NUM_FU = 6,
   parameter int TAG_W  = 5,
   parameter int XLEN   = 32
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_FU:0]             fu_valid,
   input  logic [(NUM_FU+1)*TAG_W-1:0] fu_rob_tag,
   input  logic [(NUM_FU+1)*XLEN-1:0]  fu_value,
   output logic [NUM_FU:0]             fu_ready,
   input  logic                        squash,
   input  logic [TAG_W-1:0]            branch_rob_tag,
   input  logic [TAG_W-1:0]            rob_tail_tag,
   output logic                        cdb_valid,
   output logic [TAG_W-1:0]            cdb_rob_tag,
   output logic [XLEN-1:0]             cdb_value,
   output logic [NUM_FU:0]             fu_done
);

   localparam int PTR_W = $clog2(NUM_FU + 2);

   // Tag 0 means "no tag" and is never squashed; otherwise young spans (branch, tail] modulo wrap.
   function automatic logic is_young(input logic [TAG_W-1:0] t,
                                     input logic [TAG_W-1:0] br,
                                     input logic [TAG_W-1:0] tail);
      logic y;
      if (t == '0)
         y = 1'b0;
      else if (br <= tail)
         y = (t > br) && (t <= tail);
      else
         y = (t > br) || (t <= tail);
      return y;
   endfunction

   logic [NUM_FU:1]  slot_valid;
   logic [TAG_W-1:0] slot_tag   [1:NUM_FU];
   logic [XLEN-1:0]  slot_value [1:NUM_FU];
   logic [PTR_W-1:0] rr_ptr;

   logic [NUM_FU:1]  slot_young;
   logic [NUM_FU:1]  in_young;
   logic [NUM_FU:1]  eligible;
   logic [NUM_FU:1]  capture;
   logic [NUM_FU:0]  grant;
   logic             grant_hit;
   logic [PTR_W-1:0] grant_idx;
   logic [TAG_W-1:0] grant_tag;
   logic [XLEN-1:0]  grant_value;
   logic             unused_bit0;

   assign unused_bit0 = ^{fu_valid[0], fu_rob_tag[TAG_W-1:0], fu_value[XLEN-1:0]};

   always_comb begin
      slot_young = '0;
      in_young   = '0;
      eligible   = '0;
      for (int i = 1; i <= NUM_FU; i++) begin
         slot_young[i] = squash && is_young(slot_tag[i], branch_rob_tag, rob_tail_tag);
         in_young[i]   = squash && is_young(fu_rob_tag[i*TAG_W +: TAG_W], branch_rob_tag, rob_tail_tag);
         eligible[i]   = slot_valid[i] && !slot_young[i];
      end
   end

   // Two passes: slots at or above rr_ptr first, then the wrapped-around low slots.
   always_comb begin
      grant       = '0;
      grant_hit   = 1'b0;
      grant_idx   = '0;
      grant_tag   = '0;
      grant_value = '0;
      for (int j = 1; j <= NUM_FU; j++) begin
         if (!grant_hit && eligible[j] && (PTR_W'(j) >= rr_ptr)) begin
            grant_hit   = 1'b1;
            grant[j]    = 1'b1;
            grant_idx   = PTR_W'(j);
            grant_tag   = slot_tag[j];
            grant_value = slot_value[j];
         end
      end
      for (int j = 1; j <= NUM_FU; j++) begin
         if (!grant_hit && eligible[j]) begin
            grant_hit   = 1'b1;
            grant[j]    = 1'b1;
            grant_idx   = PTR_W'(j);
            grant_tag   = slot_tag[j];
            grant_value = slot_value[j];
         end
      end
   end

   always_comb begin
      fu_ready = '0;
      capture  = '0;
      for (int i = 1; i <= NUM_FU; i++) begin
         fu_ready[i] = !slot_valid[i] || grant[i] || slot_young[i];
         capture[i]  = fu_valid[i] && fu_ready[i] && !in_young[i];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot_valid <= '0;
         for (int i = 1; i <= NUM_FU; i++) begin
            slot_tag[i]   <= '0;
            slot_value[i] <= '0;
         end
      end else begin
         for (int i = 1; i <= NUM_FU; i++) begin
            if (capture[i]) begin
               slot_valid[i] <= 1'b1;
               slot_tag[i]   <= fu_rob_tag[i*TAG_W +: TAG_W];
               slot_value[i] <= fu_value[i*XLEN +: XLEN];
            end else if (grant[i] || slot_young[i]) begin
               slot_valid[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr      <= PTR_W'(1);
         cdb_valid   <= 1'b0;
         cdb_rob_tag <= '0;
         cdb_value   <= '0;
         fu_done     <= '0;
      end else if (grant_hit) begin
         rr_ptr      <= (grant_idx == PTR_W'(NUM_FU)) ? PTR_W'(1) : grant_idx + 1'b1;
         cdb_valid   <= 1'b1;
         cdb_rob_tag <= grant_tag;
         cdb_value   <= grant_value;
         fu_done     <= grant;
      end else begin
         cdb_valid   <= 1'b0;
         cdb_rob_tag <= '0;
         cdb_value   <= '0;
         fu_done     <= '0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

   logic          clock;
   logic          reset;
   logic [6:0]    fu_valid;
   logic [34:0]   fu_rob_tag;
   logic [223:0]  fu_value;
   logic [6:0]    fu_ready;
   logic          squash;
   logic [4:0]    branch_rob_tag;
   logic [4:0]    rob_tail_tag;
   logic          cdb_valid;
   logic [4:0]    cdb_rob_tag;
   logic [31:0]   cdb_value;
   logic [6:0]    fu_done;

   int total = 0;
   int bad   = 0;

   cdb_arbiter #(.NUM_FU(6), .TAG_W(5), .XLEN(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .fu_valid       (fu_valid),
      .fu_rob_tag     (fu_rob_tag),
      .fu_value       (fu_value),
      .fu_ready       (fu_ready),
      .squash         (squash),
      .branch_rob_tag (branch_rob_tag),
      .rob_tail_tag   (rob_tail_tag),
      .cdb_valid      (cdb_valid),
      .cdb_rob_tag    (cdb_rob_tag),
      .cdb_value      (cdb_value),
      .fu_done        (fu_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic chk_cdb(input string name, input logic v, input logic [4:0] t,
                          input logic [31:0] val, input logic [6:0] d);
      chk({name, ".valid"}, 64'(cdb_valid), 64'(v));
      chk({name, ".tag"}, 64'(cdb_rob_tag), 64'(t));
      chk({name, ".value"}, 64'(cdb_value), 64'(val));
      chk({name, ".done"}, 64'(fu_done), 64'(d));
   endtask

   task automatic drive(input int i, input logic [4:0] t, input logic [31:0] v);
      fu_valid[i]          = 1'b1;
      fu_rob_tag[i*5 +: 5] = t;
      fu_value[i*32 +: 32] = v;
   endtask

   task automatic clear_all();
      fu_valid   = '0;
      fu_rob_tag = '0;
      fu_value   = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset          = 1'b1;
      squash         = 1'b0;
      branch_rob_tag = '0;
      rob_tail_tag   = '0;
      clear_all();
      tick();
      tick();
      chk_cdb("reset", 1'b0, 5'd0, 32'h0, 7'b0000000);
      chk("reset.ready", 64'(fu_ready), 64'h7E);
      reset = 1'b0;

      // round-robin from rr_ptr=1, FU1 refilled while being granted
      drive(1, 5'd1, 32'h11);
      drive(3, 5'd3, 32'h33);
      drive(5, 5'd5, 32'h55);
      tick();
      chk("rr.idle0", 64'(cdb_valid), 64'h0);
      clear_all();
      drive(1, 5'd7, 32'h77);
      #1;
      chk("rr.ready", 64'(fu_ready), 64'h56);
      tick();
      chk_cdb("rr.e1", 1'b1, 5'd1, 32'h11, 7'b0000010);
      clear_all();
      tick();
      chk_cdb("rr.e2", 1'b1, 5'd3, 32'h33, 7'b0001000);
      tick();
      chk_cdb("rr.e3", 1'b1, 5'd5, 32'h55, 7'b0100000);
      tick();
      chk_cdb("rr.e4", 1'b1, 5'd7, 32'h77, 7'b0000010);
      tick();
      chk_cdb("rr.e5", 1'b0, 5'd0, 32'h0, 7'b0000000);

      // single result, one-cycle latency, one-cycle visibility
      drive(2, 5'd5, 32'hAB);
      tick();
      chk("single.lat", 64'(cdb_valid), 64'h0);
      clear_all();
      tick();
      chk_cdb("single.e1", 1'b1, 5'd5, 32'hAB, 7'b0000100);
      tick();
      chk_cdb("single.e2", 1'b0, 5'd0, 32'h0, 7'b0000000);

      // squash without wrap: branch 4, tail 9; tag 4 and 3 survive, 6 and 9 dropped
      drive(1, 5'd3, 32'h301);
      drive(2, 5'd6, 32'h602);
      drive(3, 5'd9, 32'h903);
      drive(4, 5'd4, 32'h404);
      tick();
      clear_all();
      squash         = 1'b1;
      branch_rob_tag = 5'd4;
      rob_tail_tag   = 5'd9;
      #1;
      chk("sq.ready", 64'(fu_ready), 64'h7C);
      tick();
      chk_cdb("sq.e1", 1'b1, 5'd4, 32'h404, 7'b0010000);
      squash = 1'b0;
      tick();
      chk_cdb("sq.e2", 1'b1, 5'd3, 32'h301, 7'b0000010);
      tick();
      chk_cdb("sq.e3", 1'b0, 5'd0, 32'h0, 7'b0000000);

      // squash with wrap: branch 28, tail 2; tags 30,1 dropped, incoming 31 dropped, tag 0 kept
      drive(1, 5'd30, 32'h1E);
      drive(2, 5'd1, 32'h01);
      drive(3, 5'd20, 32'h14);
      drive(5, 5'd0, 32'h5A5A);
      tick();
      clear_all();
      squash         = 1'b1;
      branch_rob_tag = 5'd28;
      rob_tail_tag   = 5'd2;
      drive(4, 5'd31, 32'h1F);
      #1;
      chk("wrap.ready", 64'(fu_ready), 64'h5E);
      tick();
      chk_cdb("wrap.e1", 1'b1, 5'd20, 32'h14, 7'b0001000);
      clear_all();
      squash = 1'b0;
      tick();
      chk_cdb("wrap.e2", 1'b1, 5'd0, 32'h5A5A, 7'b0100000);
      tick();
      chk_cdb("wrap.e3", 1'b0, 5'd0, 32'h0, 7'b0000000);

      // drain-and-refill on FU4
      drive(4, 5'd10, 32'hA0);
      tick();
      drive(4, 5'd11, 32'hA1);
      #1;
      chk("refill.ready", 64'(fu_ready), 64'h7E);
      tick();
      chk_cdb("refill.e1", 1'b1, 5'd10, 32'hA0, 7'b0010000);
      drive(4, 5'd13, 32'hA3);
      drive(2, 5'd12, 32'hA2);
      tick();
      chk_cdb("refill.e2", 1'b1, 5'd11, 32'hA1, 7'b0010000);
      clear_all();
      tick();
      chk_cdb("refill.e3", 1'b1, 5'd12, 32'hA2, 7'b0000100);
      tick();
      chk_cdb("refill.e4", 1'b1, 5'd13, 32'hA3, 7'b0010000);
      tick();
      chk_cdb("refill.e5", 1'b0, 5'd0, 32'h0, 7'b0000000);

      // asynchronous reset mid-cycle with three slots full and the CDB busy
      drive(1, 5'd1, 32'hC1);
      drive(2, 5'd2, 32'hC2);
      drive(3, 5'd3, 32'hC3);
      drive(4, 5'd4, 32'hC4);
      tick();
      clear_all();
      tick();
      chk_cdb("arst.pre", 1'b1, 5'd1, 32'hC1, 7'b0000010);
      #2;
      reset = 1'b1;
      #1;
      chk_cdb("arst.during", 1'b0, 5'd0, 32'h0, 7'b0000000);
      chk("arst.ready", 64'(fu_ready), 64'h7E);
      #1;
      reset = 1'b0;
      tick();
      chk_cdb("arst.nostale", 1'b0, 5'd0, 32'h0, 7'b0000000);
      drive(1, 5'd21, 32'hD1);
      drive(2, 5'd22, 32'hD2);
      tick();
      clear_all();
      tick();
      chk_cdb("arst.e1", 1'b1, 5'd21, 32'hD1, 7'b0000010);
      tick();
      chk_cdb("arst.e2", 1'b1, 5'd22, 32'hD2, 7'b0000100);
      tick();
      chk_cdb("arst.e3", 1'b0, 5'd0, 32'h0, 7'b0000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
